// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: operation codes, FSM states and the
// operation-class helper used to pick the completion path.
package alu_pkg;

  // Seventeen operations need a five-bit code; the unused codes 17..31 decode as "undefined".
  localparam int OP_W = 5;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_AND  = 5'd2,
    OP_OR   = 5'd3,
    OP_XOR  = 5'd4,
    OP_SLT  = 5'd5,
    OP_SLTU = 5'd6,
    OP_SLL  = 5'd7,
    OP_SRL  = 5'd8,
    OP_SRA  = 5'd9,
    OP_SLLV = 5'd10,
    OP_SRLV = 5'd11,
    OP_SRAV = 5'd12,
    OP_LUI  = 5'd13,
    OP_MUL  = 5'd14,
    OP_DIV  = 5'd15,
    OP_DIVU = 5'd16
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_t;

  typedef enum logic [1:0] {
    CLS_SINGLE = 2'd0,
    CLS_MUL    = 2'd1,
    CLS_DIV    = 2'd2
  } op_cls_t;

  function automatic op_cls_t op_class(input alu_op_t op);
    case (op)
      OP_MUL:          return CLS_MUL;
      OP_DIV, OP_DIVU: return CLS_DIV;
      default:         return CLS_SINGLE;
    endcase
  endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Request/result bus of the multi-cycle ALU; master issues operations and
// consumes results, slave is the ALU.
interface alu_mc_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) ();
  import alu_pkg::*;

  localparam int SH_W = $clog2(XLEN);

  logic             in_valid;
  logic             in_ready;
  alu_op_t          op;
  logic [XLEN-1:0]  s;
  logic [XLEN-1:0]  t;
  logic [SH_W-1:0]  shamt;
  logic [TAG_W-1:0] tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  d;
  logic [TAG_W-1:0] out_tag;
  logic             div_by_zero;

  modport master (
    output in_valid, op, s, t, shamt, tag, out_ready,
    input  in_ready, out_valid, d, out_tag, div_by_zero
  );

  modport slave (
    input  in_valid, op, s, t, shamt, tag, out_ready,
    output in_ready, out_valid, d, out_tag, div_by_zero
  );

endinterface

// File: rtl/alu_div_iter.sv
// Radix-2 restoring divider: operands are turned into magnitudes on start, one
// quotient bit per cycle, sign and divide-by-zero fixed up on the output.
module alu_div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic            sgn,
  input  logic [XLEN-1:0] s,
  input  logic [XLEN-1:0] t,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic            dbz
);

  localparam int CNT_W = $clog2(XLEN);

  logic signed [XLEN-1:0] s_sg, t_sg;
  logic [XLEN-1:0]        s_mag, t_mag;
  logic [XLEN-1:0]        rem_q, quo_q, dvs_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   neg_q, dbz_q, done_q;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  function automatic logic [2*XLEN-1:0] div_step(input logic [XLEN-1:0] rem,
                                                 input logic [XLEN-1:0] quo,
                                                 input logic [XLEN-1:0] dvs);
    logic [XLEN:0] rem_sh, trial;
    rem_sh = {rem, quo[XLEN-1]};
    trial  = rem_sh - {1'b0, dvs};
    if (trial[XLEN]) return {rem_sh[XLEN-1:0], quo[XLEN-2:0], 1'b0};
    else             return {trial[XLEN-1:0], quo[XLEN-2:0], 1'b1};
  endfunction

  assign s_sg  = s;
  assign t_sg  = t;
  assign s_mag = (sgn && s_sg < 0) ? -s : s;
  assign t_mag = (sgn && t_sg < 0) ? -t : t;

  // The first step happens on the start edge so the last bit lands XLEN-1 cycles later.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      neg_q  <= 1'b0;
      dbz_q  <= 1'b0;
      done_q <= 1'b0;
    end else if (start) begin
      {rem_q, quo_q} <= div_step('0, s_mag, t_mag);
      dvs_q  <= t_mag;
      cnt_q  <= CNT_W'(XLEN-1);
      neg_q  <= sgn && (s[XLEN-1] ^ t[XLEN-1]);
      dbz_q  <= (t == '0);
      done_q <= 1'b0;
    end else if (cnt_q != '0) begin
      {rem_q, quo_q} <= div_step(rem_q, quo_q, dvs_q);
      cnt_q  <= cnt_q - 1'b1;
      done_q <= (cnt_q == CNT_W'(1));
    end
  end

  // Most-negative / -1 needs no special case: the magnitude wraps back to itself.
  assign quotient = dbz_q ? '1 : (neg_q ? -quo_q : quo_q);
  assign dbz      = dbz_q;
  assign done     = done_q;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops, pipelined multiply and
// an iterative divider behind one valid/ready request and result handshake.
module alu_mc
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 3,
  parameter int TAG_W   = 5
) (
  input  logic     clk,
  input  logic     rstn,
  alu_mc_if.slave  bus
);

  localparam int SH_W    = $clog2(XLEN);
  localparam int CNT_W   = $clog2(XLEN);
  localparam int HALF    = XLEN / 2;
  localparam int MUL_CNT = (MUL_LAT > 1) ? MUL_LAT - 2 : 0;

  alu_state_t       state_q, state_d;
  op_cls_t          cls_in, cls_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  d_q;
  logic [TAG_W-1:0] tag_q;
  logic             dbz_q;

  logic             accept, acc_mul, multi_in, fin;
  logic [XLEN-1:0]  res_now, prod_now, mul_tail;
  logic             mul_tail_vld;
  logic             div_done, div_dbz;
  logic [XLEN-1:0]  div_quo;

  logic signed [XLEN-1:0] s_sg, t_sg;

  assign s_sg     = bus.s;
  assign t_sg     = bus.t;
  assign cls_in   = op_class(bus.op);
  assign bus.in_ready = (state_q == IDLE) || (state_q == DONE && bus.out_ready);
  assign accept   = bus.in_valid && bus.in_ready;
  assign acc_mul  = accept && (cls_in == CLS_MUL);
  assign multi_in = (cls_in == CLS_DIV) || (cls_in == CLS_MUL && MUL_LAT > 1);
  assign prod_now = bus.s * bus.t;

  always_comb begin
    res_now = '0;
    case (bus.op)
      OP_ADD:  res_now = bus.s + bus.t;
      OP_SUB:  res_now = bus.s - bus.t;
      OP_AND:  res_now = bus.s & bus.t;
      OP_OR:   res_now = bus.s | bus.t;
      OP_XOR:  res_now = bus.s ^ bus.t;
      OP_SLT:  res_now = {{(XLEN-1){1'b0}}, (s_sg < t_sg)};
      OP_SLTU: res_now = {{(XLEN-1){1'b0}}, (bus.s < bus.t)};
      OP_SLL:  res_now = bus.t << bus.shamt;
      OP_SRL:  res_now = bus.t >> bus.shamt;
      OP_SRA:  res_now = t_sg >>> bus.shamt;
      OP_SLLV: res_now = bus.t << bus.s[SH_W-1:0];
      OP_SRLV: res_now = bus.t >> bus.s[SH_W-1:0];
      OP_SRAV: res_now = t_sg >>> bus.s[SH_W-1:0];
      OP_LUI:  res_now = {bus.t[HALF-1:0], {HALF{1'b0}}};
      OP_MUL:  res_now = prod_now;
      default: res_now = '0;
    endcase
  end

  // Multiply pipeline: stage p0 registers the product, later stages only delay it.
  generate
    if (MUL_LAT > 1) begin : g_mul_pipe
      logic [XLEN-1:0]    prod_p [MUL_LAT-1];
      logic [MUL_LAT-2:0] vld_p;

      always_ff @(posedge clk) begin
        prod_p[0] <= prod_now;
        for (int i = 1; i < MUL_LAT-1; i++) prod_p[i] <= prod_p[i-1];
      end

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          vld_p <= '0;
        end else begin
          vld_p[0] <= acc_mul;
          for (int i = 1; i < MUL_LAT-1; i++) vld_p[i] <= vld_p[i-1];
        end
      end

      assign mul_tail     = prod_p[MUL_LAT-2];
      assign mul_tail_vld = vld_p[MUL_LAT-2];
    end else begin : g_mul_direct
      assign mul_tail     = prod_now;
      assign mul_tail_vld = 1'b1;
    end
  endgenerate

  alu_div_iter #(.XLEN(XLEN)) u_div (
    .clk      (clk),
    .rstn     (rstn),
    .start    (accept && cls_in == CLS_DIV),
    .sgn      (bus.op == OP_DIV),
    .s        (bus.s),
    .t        (bus.t),
    .done     (div_done),
    .quotient (div_quo),
    .dbz      (div_dbz)
  );

  assign fin = (cnt_q == '0) && ((cls_q == CLS_DIV) ? div_done : mul_tail_vld);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = multi_in ? BUSY : DONE;
      BUSY:    if (fin) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = accept ? (multi_in ? BUSY : DONE) : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Result stage: single-cycle results land on accept, multi-cycle ones when fin rises.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cls_q   <= CLS_SINGLE;
      cnt_q   <= '0;
      d_q     <= '0;
      tag_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        tag_q <= bus.tag;
        cls_q <= cls_in;
        dbz_q <= 1'b0;
        if (cls_in == CLS_DIV)      cnt_q <= CNT_W'(XLEN-1);
        else if (cls_in == CLS_MUL) cnt_q <= CNT_W'(MUL_CNT);
        else                        cnt_q <= '0;
        if (!multi_in) d_q <= res_now;
      end else if (state_q == BUSY) begin
        if (fin) begin
          d_q   <= (cls_q == CLS_DIV) ? div_quo : mul_tail;
          dbz_q <= (cls_q == CLS_DIV) && div_dbz;
        end else if (cnt_q != '0) begin
          cnt_q <= cnt_q - 1'b1;
        end
      end
    end
  end

  assign bus.out_valid   = (state_q == DONE);
  assign bus.d           = d_q;
  assign bus.out_tag     = tag_q;
  assign bus.div_by_zero = dbz_q;

endmodule
